// File: rtl/x_uart_tx.sv
// x_uart_tx: 8N1 UART transmitter for the host link. Bytes arrive on a
// valid/ready handshake, wait in a small FIFO, and are shifted out LSB first
// on o_tx. The bit period is p_clk_hz/p_baud + 1 cycles so the line can be
// looped straight back into the matching receiver.
//
// state   | meaning
// --------+-----------------------------------------------------------
// s_idle  | line high, waiting for the FIFO to hold a byte
// s_start | driving the start bit (low) for one bit period
// s_data  | driving data bit bit_idx, shift register holds remaining bits
// s_stop  | driving the stop bit (high); may chain straight into s_start
module x_uart_tx #(
  parameter int p_clk_hz = 1200000,
  parameter int p_baud   = 115200,
  parameter int p_depth  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int p_timer_top = p_clk_hz / p_baud;
  localparam int c_tmr_w     = $clog2(p_timer_top + 1);
  localparam int c_ptr_w     = $clog2(p_depth);
  localparam int c_cnt_w     = c_ptr_w + 1;

  localparam logic [c_tmr_w-1:0] c_tmr_top = c_tmr_w'(p_timer_top);
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(p_depth);

  localparam logic [1:0] s_idle  = 2'd0;
  localparam logic [1:0] s_start = 2'd1;
  localparam logic [1:0] s_data  = 2'd2;
  localparam logic [1:0] s_stop  = 2'd3;

  logic [7:0]         mem [p_depth];
  logic [c_ptr_w-1:0] wr_ptr;
  logic [c_ptr_w-1:0] rd_ptr;
  logic [c_cnt_w-1:0] count;

  logic [1:0]         state;
  logic [c_tmr_w-1:0] timer;
  logic [7:0]         shift;
  logic [2:0]         bit_idx;

  logic push;
  logic pop;
  logic fifo_empty;
  logic tmr_wrap;

  assign o_ready    = (count != c_full);
  assign fifo_empty = (count == '0);
  assign push       = i_valid & o_ready;
  assign tmr_wrap   = (timer == c_tmr_top);
  assign o_busy     = (state != s_idle) | ~fifo_empty;

  // The FSM pops only when it loads a new frame: from idle, or at the end of a stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      s_idle:  pop = ~fifo_empty;
      s_stop:  pop = tmr_wrap & ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bit timer, frame sequencing and the registered serial output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= s_idle;
      timer   <= '0;
      shift   <= '0;
      bit_idx <= '0;
      o_tx    <= 1'b1;
    end else begin
      // Held at zero in idle so every frame starts on a fresh bit period.
      if ((state == s_idle) || tmr_wrap) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      case (state)
        s_idle: begin
          o_tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            o_tx  <= 1'b0;
            state <= s_start;
          end
        end
        s_start: begin
          if (tmr_wrap) begin
            o_tx    <= shift[0];
            bit_idx <= '0;
            state   <= s_data;
          end
        end
        s_data: begin
          if (tmr_wrap) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 1'b1;
              o_tx    <= shift[1];
            end else begin
              o_tx  <= 1'b1;
              state <= s_stop;
            end
          end
        end
        s_stop: begin
          if (tmr_wrap) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              o_tx  <= 1'b0;
              state <= s_start;
            end else begin
              state <= s_idle;
            end
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= s_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_uart_tx.sv
// tb_x_uart_tx: scoreboard bench for x_uart_tx at default parameters
// (bit period 1200000/115200 + 1 = 11 cycles, frame 110 cycles, depth 4).
// Accepted bytes are queued on the handshake edge; a line monitor decodes
// every frame cycle by cycle and pops/compares against that queue.
module tb_x_uart_tx;

  localparam int c_bit = 11;
  localparam int c_frame = 10 * c_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;

  int vec = 0;
  int miss = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 clk = ~clk;

  x_uart_tx dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid),
    .o_ready(ready),
    .i_data (data),
    .o_tx   (tx),
    .o_busy (busy)
  );

  // Scoreboard producer: record each byte the handshake accepts; reset discards the queue.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (valid && ready) exp_q.push_back(data);
  end

  // Line monitor: checks every cycle of each frame against the queued byte.
  bit         mon_active = 1'b0;
  bit         mon_err = 1'b0;
  bit         mon_skip = 1'b0;
  int         mon_k = 0;
  logic [9:0] mon_frame = '0;
  logic [9:0] rx_frame = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_k = 0;
        mon_err = 1'b0;
        rx_frame = '0;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          mon_skip = 1'b1;
          vec++;
          miss++;
          $display("FAIL unexpected_frame: cycle %0d got start bit, want idle line", cyc);
        end else begin
          mon_skip = 1'b0;
          mon_frame = {1'b1, exp_q.pop_front(), 1'b0};
        end
      end
      if (mon_active) begin
        if (mon_k % c_bit == c_bit / 2) rx_frame[mon_k / c_bit] = tx;
        if (!mon_skip && tx !== mon_frame[mon_k / c_bit]) mon_err = 1'b1;
        mon_k++;
        if (mon_k == c_frame) begin
          mon_active = 1'b0;
          if (!mon_skip) begin
            vec++;
            if (mon_err) begin
              miss++;
              $display("FAIL frame: got frame %03h (or bad bit timing), want %03h", rx_frame, mon_frame);
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_wait(input logic [7:0] b, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    valid = 1'b1;
    data = b;
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = (ready === 1'b1);
      if (!acc) stalls++;
      tick();
    end
    valid = 1'b0;
    if (!acc) begin
      vec++;
      miss++;
      $display("FAIL push_timeout: byte %02h got no ready, want accepted", b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      vec++;
      miss++;
      $display("FAIL %s_timeout: got still busy, want idle", name);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int n;

    // Reset held 3 cycles with a byte offered: must be ignored.
    rst = 1'b1;
    valid = 1'b1;
    data = 8'hFF;
    repeat (3) begin
      tick();
      check("rst_tx", tx, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0;
    valid = 1'b0;
    repeat (20) tick();
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);

    // Single byte 0x55: start bit one cycle after acceptance, 110 busy cycles from start.
    valid = 1'b1;
    data = 8'h55;
    tick();
    valid = 1'b0;
    check("accept_tx", tx, 1);
    check("accept_busy", busy, 1);
    tick();
    check("start_latency", tx, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("busy_cycles", n, c_frame);
    check("after_frame_tx", tx, 1);
    wait_idle("single");

    // Fill and back-pressure: lead byte 0x00, then 0x01..0x05.
    start_q.delete();
    push_wait(8'h00, stalls);
    for (int i = 1; i <= 4; i++) begin
      push_wait(8'(i), stalls);
      check("fill_stalls", stalls, 0);
    end
    check("ready_full", ready, 0);
    push_wait(8'h05, stalls);
    check("bp_stalls", stalls, 107);
    wait_idle("fill");
    check("fill_frames", start_q.size(), 6);
    for (int i = 1; i < 6 && i < start_q.size(); i++) begin
      check("gapless", start_q[i] - start_q[i-1], c_frame);
    end

    // Simultaneous push and pop on the stop-bit wrap edge with count at 2.
    valid = 1'b1;
    data = 8'h3C;
    tick();
    data = 8'hC3;
    tick();
    data = 8'h96;
    tick();
    valid = 1'b0;
    repeat (108) tick();
    check("stop_before_pop", tx, 1);
    valid = 1'b1;
    data = 8'h69;
    tick();
    valid = 1'b0;
    check("simul_count", 32'(dut.count), 2);
    check("simul_start", tx, 0);
    check("simul_ready", ready, 1);
    wait_idle("simul");

    // Reset during data bit 3 of 0xA5 with two bytes still queued.
    valid = 1'b1;
    data = 8'hA5;
    tick();
    data = 8'h11;
    tick();
    data = 8'h22;
    tick();
    valid = 1'b0;
    repeat (48) tick();
    check("bit3_level", tx, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 1);
    repeat (300) tick();
    check("midrst_quiet_tx", tx, 1);
    check("midrst_quiet_busy", busy, 0);

    // Loopback-style stream: 256 random bytes with random valid gaps.
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push_wait(8'($urandom_range(0, 255)), stalls);
    end
    wait_idle("loopback");
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
